sipo_deser: RTL and testbench

Serial-in, parallel-out deserializer that receives the bit stream produced by the serializer stage, least-significant bit first, and reassembles it into WIDTH-bit words. Completed words go into a single output holding register with a valid/ready handshake toward the downstream consumer. A sync strobe realigns word boundaries, and a sticky overrun flag records any word dropped because the holding register was still full.

---
 rtl/sipo_deser.sv | 98 +++++++++
 tb/tb_sipo_deser.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: assembles WIDTH-bit words from a bit stream
// into a single holding register with a valid/ready handshake and a sticky overrun flag.
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       si,
    input  logic                       si_valid,
    input  logic                       sync,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       overrun,
    input  logic                       ovr_clr,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             ovr_q, ovr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_src, shifted;
    logic             ovr_set;

    always_comb begin
        // A sync strobe drops the partial word before the current bit shifts in.
        shift_src = sync ? '0 : sr_q;
        if (MSB_FIRST) shifted = {shift_src[WIDTH-2:0], si};
        else           shifted = {si, shift_src[WIDTH-1:1]};

        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        dv_d    = dv_q;
        ovr_set = 1'b0;

        if (dv_q && dout_ready) dv_d = 1'b0;

        if (si_valid) begin
            if (!sync && cnt_q == LAST) begin
                sr_d    = '0;
                cnt_d   = '0;
                state_d = IDLE;
                if (!dv_q || dout_ready) begin
                    dout_d = shifted;
                    dv_d   = 1'b1;
                end else begin
                    ovr_set = 1'b1;
                end
            end else begin
                sr_d    = shifted;
                cnt_d   = sync ? CW'(1) : cnt_q + CW'(1);
                state_d = SHIFT;
            end
        end else if (sync) begin
            sr_d    = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end

        // Set has priority over clear when both land on the same edge.
        ovr_d = (ovr_q & ~ovr_clr) | ovr_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed vector bench for sipo_deser: LSB-first table plus reset and MSB-first sequences.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       si = 1'b0, si_valid = 1'b0, sync = 1'b0, dout_ready = 1'b0, ovr_clr = 1'b0;
    logic [3:0] dout, dout_m;
    logic       dout_valid, overrun, dout_valid_m, overrun_m;
    logic [1:0] bit_cnt, bit_cnt_m;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .si(si), .si_valid(si_valid), .sync(sync),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .overrun(overrun), .ovr_clr(ovr_clr), .bit_cnt(bit_cnt)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .si(si), .si_valid(si_valid), .sync(sync),
        .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
        .overrun(overrun_m), .ovr_clr(ovr_clr), .bit_cnt(bit_cnt_m)
    );

    typedef struct {
        logic       sy, vl, b, rdy, clr;
        logic [3:0] e_dout;
        logic       e_dv, e_ovr;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic sy, vl, b, rdy, clr,
                     input logic [3:0] ed, input logic edv, eovr, input logic [1:0] ecnt);
        vec_t r;
        r.sy = sy; r.vl = vl; r.b = b; r.rdy = rdy; r.clr = clr;
        r.e_dout = ed; r.e_dv = edv; r.e_ovr = eovr; r.e_cnt = ecnt;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic sy, vl, b, rdy, clr);
        sync = sy; si_valid = vl; si = b; dout_ready = rdy; ovr_clr = clr;
    endtask

    initial begin
        // basic word 1,1,0,1 with sync on the first bit -> 4'hB
        v(1,1,1,1,0, 4'h0,0,0,1);
        v(0,1,1,1,0, 4'h0,0,0,2);
        v(0,1,0,1,0, 4'h0,0,0,3);
        v(0,1,1,1,0, 4'hB,1,0,0);
        v(0,0,0,1,0, 4'hB,0,0,0);
        // gapped bits, three idle cycles between each
        v(0,1,1,1,0, 4'hB,0,0,1);
        for (int i = 0; i < 3; i++) v(0,0,0,1,0, 4'hB,0,0,1);
        v(0,1,1,1,0, 4'hB,0,0,2);
        for (int i = 0; i < 3; i++) v(0,0,0,1,0, 4'hB,0,0,2);
        v(0,1,0,1,0, 4'hB,0,0,3);
        for (int i = 0; i < 3; i++) v(0,0,0,1,0, 4'hB,0,0,3);
        v(0,1,1,1,0, 4'hB,1,0,0);
        v(0,0,0,1,0, 4'hB,0,0,0);
        // overrun: 4'h3 then 4'h5 with the consumer stalled
        v(0,1,1,0,0, 4'hB,0,0,1);
        v(0,1,1,0,0, 4'hB,0,0,2);
        v(0,1,0,0,0, 4'hB,0,0,3);
        v(0,1,0,0,0, 4'h3,1,0,0);
        v(0,1,1,0,0, 4'h3,1,0,1);
        v(0,1,0,0,0, 4'h3,1,0,2);
        v(0,1,1,0,0, 4'h3,1,0,3);
        v(0,1,0,0,0, 4'h3,1,1,0);
        v(0,0,0,1,0, 4'h3,0,1,0);
        v(0,0,0,0,1, 4'h3,0,0,0);
        // set wins over clear on the same edge
        v(0,1,1,0,0, 4'h3,0,0,1);
        v(0,1,1,0,0, 4'h3,0,0,2);
        v(0,1,1,0,0, 4'h3,0,0,3);
        v(0,1,1,0,0, 4'hF,1,0,0);
        v(0,1,0,0,0, 4'hF,1,0,1);
        v(0,1,0,0,0, 4'hF,1,0,2);
        v(0,1,0,0,0, 4'hF,1,0,3);
        v(0,1,0,0,1, 4'hF,1,1,0);
        v(0,0,0,1,1, 4'hF,0,0,0);
        // 4'hA then 4'h6 back to back, drain on the edge the second word completes
        v(0,1,0,0,0, 4'hF,0,0,1);
        v(0,1,1,0,0, 4'hF,0,0,2);
        v(0,1,0,0,0, 4'hF,0,0,3);
        v(0,1,1,0,0, 4'hA,1,0,0);
        v(0,1,0,0,0, 4'hA,1,0,1);
        v(0,1,1,0,0, 4'hA,1,0,2);
        v(0,1,1,0,0, 4'hA,1,0,3);
        v(0,1,0,1,0, 4'h6,1,0,0);
        v(0,0,0,1,0, 4'h6,0,0,0);
        // resync: two bits discarded, sync with si=0, then 1,1,1 -> 4'hE
        v(0,1,1,1,0, 4'h6,0,0,1);
        v(0,1,1,1,0, 4'h6,0,0,2);
        v(1,1,0,1,0, 4'h6,0,0,1);
        v(0,1,1,1,0, 4'h6,0,0,2);
        v(0,1,1,1,0, 4'h6,0,0,3);
        v(0,1,1,1,0, 4'hE,1,0,0);
        // sync without a bit empties the shifter
        v(0,1,1,1,0, 4'hE,0,0,1);
        v(1,0,0,1,0, 4'hE,0,0,0);
        v(0,0,0,1,0, 4'hE,0,0,0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", -1, dout, 4'h0);
        chk("rst_valid", -1, dout_valid, 1'b0);
        chk("rst_ovr", -1, overrun, 1'b0);
        chk("rst_cnt", -1, bit_cnt, 2'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sy, tbl[i].vl, tbl[i].b, tbl[i].rdy, tbl[i].clr);
            @(posedge clk);
            #1;
            chk("dout", i, dout, tbl[i].e_dout);
            chk("dout_valid", i, dout_valid, tbl[i].e_dv);
            chk("overrun", i, overrun, tbl[i].e_ovr);
            chk("bit_cnt", i, bit_cnt, tbl[i].e_cnt);
        end

        // pending word plus three bits, then asynchronous reset mid-cycle
        drive(1,1,1,0,0);
        @(posedge clk); #1;
        drive(0,1,1,0,0);
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_valid", -2, dout_valid, 1'b1);
        chk("pre_rst_dout", -2, dout, 4'hF);
        drive(0,1,0,1,0);
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_cnt", -2, bit_cnt, 2'd3);
        drive(0,0,0,0,0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_dout", -3, dout, 4'h0);
        chk("async_valid", -3, dout_valid, 1'b0);
        chk("async_ovr", -3, overrun, 1'b0);
        chk("async_cnt", -3, bit_cnt, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // bits 1,0,0,0 with no sync: first bit after reset is bit 0
        drive(0,1,1,1,0);
        @(posedge clk); #1;
        chk("msb_cnt1", -4, bit_cnt_m, 2'd1);
        drive(0,1,0,1,0);
        repeat (3) begin @(posedge clk); #1; end
        chk("msb_dout", -4, dout_m, 4'h8);
        chk("msb_valid", -4, dout_valid_m, 1'b1);
        chk("lsb_dout", -4, dout, 4'h1);
        chk("lsb_valid", -4, dout_valid, 1'b1);
        drive(0,0,0,1,0);
        @(posedge clk); #1;
        chk("msb_drained", -4, dout_valid_m, 1'b0);
        chk("msb_hold", -4, dout_m, 4'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
